// File: rtl/prog_clock_divider.sv
// prog_clock_divider
//
// Multi-channel, runtime-programmable clock divider. Each channel toggles its
// square wave `op` after `active_div` enabled cycles. When the optional tick
// feature is built, each channel also raises a one-cycle `tick` strobe on
// every toggle.
//
// A new divisor is staged as "pending" and is applied only at the channel's
// next wrap, or immediately on a restart. This allows divisors to change at
// run time without producing a truncated half-period.
//
// Optional feature macro: PROG_CLKDIV_TICK_EN
//   defined     -> `tick` is registered and driven.
//   not defined -> `tick` is tied to 0 and no tick registers are built.
//
// Ports:
//   clock    in   system clock; all state updates on the rising edge
//   reset    in   asynchronous, active-high reset
//   enable   in   [NCH]   per-channel count enable (low freezes the channel)
//   restart  in   [NCH]   per-channel synchronous phase restart (overrides enable)
//   div_wr   in   divisor write strobe
//   div_sel  in   [SELW]  target channel for div_wr
//   div_data in   [WIDTH] new half-period in cycles (0 is rejected)
//   op       out  [NCH]   divided square waves
//   tick     out  [NCH]   one-cycle strobe on each op toggle
//   wr_err   out  one-cycle pulse, one cycle after a rejected write
module prog_clock_divider #(
    parameter int  NCH         = 4,
    parameter int  WIDTH       = 32,
    parameter int  DEFAULT_DIV = 50000000,
    localparam int SELW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   enable,
    input  logic [NCH-1:0]   restart,
    input  logic             div_wr,
    input  logic [SELW-1:0]  div_sel,
    input  logic [WIDTH-1:0] div_data,
    output logic [NCH-1:0]   op,
    output logic [NCH-1:0]   tick,
    output logic             wr_err
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    // One extra bit so that NCH itself is representable when div_sel is narrow.
    localparam logic [SELW:0]    NCH_LIM = (SELW + 1)'(NCH);

    logic sel_ok;
    logic wr_ok;

    assign sel_ok = ({1'b0, div_sel} < NCH_LIM);
    assign wr_ok  = div_wr && (div_data != '0) && sel_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= div_wr && !wr_ok;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] active_div;
        logic [WIDTH-1:0] pending_div;
        logic             pending_vld;
        logic             op_r;
        logic             wr_hit;
        logic             wrap;

        assign wr_hit = wr_ok && (div_sel == SELW'(i));
        // active_div is never 0, so the subtraction cannot underflow. Using >=
        // means an out-of-range count still wraps on the next enabled cycle.
        assign wrap   = (count >= active_div - WIDTH'(1));

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                count       <= '0;
                op_r        <= 1'b0;
                active_div  <= DIV_RST;
                pending_vld <= 1'b0;
            end else if (restart[i]) begin
                // A divisor written in the restart cycle takes priority over an
                // older pending one; either way it becomes active at once.
                count       <= '0;
                op_r        <= 1'b0;
                pending_vld <= 1'b0;
                if (wr_hit) begin
                    active_div <= div_data;
                end else if (pending_vld) begin
                    active_div <= pending_div;
                end
            end else begin
                if (enable[i]) begin
                    if (wrap) begin
                        count <= '0;
                        op_r  <= ~op_r;
                        if (pending_vld) begin
                            active_div  <= pending_div;
                            pending_vld <= 1'b0;
                        end
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end
                // A write landing on a wrap edge is staged for the following
                // wrap. It overrides the clear above.
                if (wr_hit) begin
                    pending_vld <= 1'b1;
                end
            end
        end

        // Staged divisor data. It is only consumed while pending_vld is set,
        // so it does not need a reset.
        always_ff @(posedge clock) begin
            if (wr_hit) begin
                pending_div <= div_data;
            end
        end

        assign op[i] = op_r;

`ifdef PROG_CLKDIV_TICK_EN
        logic tick_r;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                tick_r <= 1'b0;
            end else begin
                tick_r <= enable[i] && !restart[i] && wrap;
            end
        end

        assign tick[i] = tick_r;
`else
        assign tick[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Testbench for prog_clock_divider.
//
// The reference model tracks, for each channel, how many enabled cycles remain
// until the next toggle, together with an optional staged divisor. A compare
// process checks op, tick and wr_err against this model on every falling
// edge. Directed literal checks pin the model to hand-derived waveforms, and
// a randomized phase then exercises enable, restart, writes and resets.
module tb_prog_clock_divider;

    localparam int NCH   = 3;
    localparam int WIDTH = 16;
    localparam int DEF   = 4;
    localparam int SELW  = 2;
`ifdef PROG_CLKDIV_TICK_EN
    localparam bit TK = 1'b1;
`else
    localparam bit TK = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   enable = '0;
    logic [NCH-1:0]   restart = '0;
    logic             div_wr = 1'b0;
    logic [SELW-1:0]  div_sel = '0;
    logic [WIDTH-1:0] div_data = '0;
    logic [NCH-1:0]   op;
    logic [NCH-1:0]   tick;
    logic             wr_err;

    prog_clock_divider #(
        .NCH        (NCH),
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .restart (restart),
        .div_wr  (div_wr),
        .div_sel (div_sel),
        .div_data(div_data),
        .op      (op),
        .tick    (tick),
        .wr_err  (wr_err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining enabled cycles in the current half-period,
    // the divisor in force, and the staged divisor (0 means none staged).
    int left_m [NCH];
    int act_m  [NCH];
    int pend_m [NCH];
    bit op_m   [NCH];
    bit tick_m [NCH];
    bit err_m;
    bit wr_m;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            err_m = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                left_m[c] = DEF;
                act_m[c]  = DEF;
                pend_m[c] = 0;
                op_m[c]   = 1'b0;
                tick_m[c] = 1'b0;
            end
        end else begin
            err_m = div_wr && (div_data == 0 || int'(div_sel) >= NCH);
            for (int c = 0; c < NCH; c++) begin
                wr_m = div_wr && (div_data != 0) && (int'(div_sel) == c);
                tick_m[c] = 1'b0;
                if (restart[c]) begin
                    op_m[c] = 1'b0;
                    if (wr_m) act_m[c] = int'(div_data);
                    else if (pend_m[c] != 0) act_m[c] = pend_m[c];
                    pend_m[c] = 0;
                    left_m[c] = act_m[c];
                end else begin
                    if (enable[c]) begin
                        left_m[c] = left_m[c] - 1;
                        if (left_m[c] == 0) begin
                            op_m[c]   = ~op_m[c];
                            tick_m[c] = 1'b1;
                            if (pend_m[c] != 0) begin
                                act_m[c]  = pend_m[c];
                                pend_m[c] = 0;
                            end
                            left_m[c] = act_m[c];
                        end
                    end
                    if (wr_m) pend_m[c] = int'(div_data);
                end
            end
        end
    end

    logic [NCH-1:0] eo;
    logic [NCH-1:0] et;

    always @(negedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            eo[c] = op_m[c];
            et[c] = TK ? tick_m[c] : 1'b0;
        end
        chk("op_vs_model", 32'(op), 32'(eo));
        chk("tick_vs_model", 32'(tick), 32'(et));
        chk("wr_err_vs_model", 32'(wr_err), 32'(err_m));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a falling edge. Sets wr_err up with a rejected write, then
    // asserts reset between edges and checks the outputs clear immediately.
    task automatic async_reset();
        div_wr   = 1'b1;
        div_sel  = '0;
        div_data = '0;
        @(posedge clock);
        #1;
        chk("pre_rst_wr_err", 32'(wr_err), 32'd1);
        #1;
        div_wr = 1'b0;
        reset  = 1'b1;
        #1;
        chk("async_rst_op", 32'(op), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_wr_err", 32'(wr_err), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        reset  = 1'b0;
        enable = 3'b001;

        // Default half-period 4: ch0 toggles at edges 4, 8.
        step(3);
        chk("dflt_op0_e3", 32'(op[0]), 32'd0);
        step(1);
        chk("dflt_op0_e4", 32'(op[0]), 32'd1);
        chk("dflt_tick0_e4", 32'(tick[0]), 32'(TK));
        step(1);
        chk("dflt_tick0_e5", 32'(tick[0]), 32'd0);
        chk("idle_ch12_e5", 32'(op[2:1]), 32'd0);
        step(3);
        chk("dflt_op0_e8", 32'(op[0]), 32'd0);

        // Write 2 two cycles into the half-period: old half completes at e12.
        step(2);
        div_wr = 1'b1; div_sel = 2'd0; div_data = 16'd2;
        step(1);
        div_wr = 1'b0;
        chk("wr_old_half_e11", 32'(op[0]), 32'd0);
        step(1);
        chk("wr_old_half_e12", 32'(op[0]), 32'd1);
        step(1);
        chk("wr_new_half_e13", 32'(op[0]), 32'd1);
        step(1);
        chk("wr_new_half_e14", 32'(op[0]), 32'd0);
        step(2);
        chk("wr_new_half_e16", 32'(op[0]), 32'd1);

        // Freeze ch0 for 3 cycles: toggle moves from e18 to e21.
        step(1);
        enable = 3'b000;
        step(3);
        chk("frozen_op0_e20", 32'(op[0]), 32'd1);
        chk("frozen_tick0_e20", 32'(tick[0]), 32'd0);
        enable = 3'b001;
        step(1);
        chk("resume_op0_e21", 32'(op[0]), 32'd0);
        chk("resume_tick0_e21", 32'(tick[0]), 32'(TK));

        // Write 3 to ch1 together with restart[1]: first toggle at e25.
        enable  = 3'b011;
        restart = 3'b010;
        div_wr = 1'b1; div_sel = 2'd1; div_data = 16'd3;
        step(1);
        restart = '0;
        div_wr  = 1'b0;
        chk("restart_op1_e22", 32'(op[1]), 32'd0);
        step(2);
        chk("restart_op1_e24", 32'(op[1]), 32'd0);
        step(1);
        chk("restart_op1_e25", 32'(op[1]), 32'd1);

        // Rejected writes: zero data, then an out-of-range channel.
        div_wr = 1'b1; div_sel = 2'd0; div_data = 16'd0;
        step(1);
        div_wr = 1'b0;
        chk("err_zero_e26", 32'(wr_err), 32'd1);
        step(1);
        chk("err_zero_e27", 32'(wr_err), 32'd0);
        div_wr = 1'b1; div_sel = 2'd3; div_data = 16'd5;
        step(1);
        div_wr = 1'b0;
        chk("err_sel_e28", 32'(wr_err), 32'd1);
        chk("err_keeps_op1_e28", 32'(op[1]), 32'd0);
        step(1);
        chk("err_sel_e29", 32'(wr_err), 32'd0);
        chk("err_keeps_op0_e29", 32'(op[0]), 32'd0);

        // Mid-count async reset: ch0 returns to the default half-period.
        async_reset();
        enable  = 3'b001;
        restart = '0;
        step(3);
        chk("post_rst_op0_e3", 32'(op[0]), 32'd0);
        step(1);
        chk("post_rst_op0_e4", 32'(op[0]), 32'd1);
        chk("post_rst_op1_e4", 32'(op[1]), 32'd0);

        // Randomized phase, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 500) begin
                async_reset();
            end
            for (int c = 0; c < NCH; c++) begin
                enable[c]  = ($urandom_range(0, 7) != 0);
                restart[c] = ($urandom_range(0, 19) == 0);
            end
            div_wr   = ($urandom_range(0, 5) == 0);
            div_sel  = SELW'($urandom_range(0, 3));
            div_data = WIDTH'($urandom_range(0, 6));
            step(1);
        end
        div_wr  = 1'b0;
        restart = '0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
